// File: rtl/booth_pkg.sv
// Shared definitions for the Booth job sequencer: FSM encoding and parameter defaults.
package booth_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_M    = 3'd1,
    ST_LOAD_Q    = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HOLD      = 3'd5
  } booth_state_e;

endpackage

// File: rtl/booth_timeout_ctr.sv
// Watchdog for the multiplier handshake: counts wait cycles, flags the last allowed one.
module booth_timeout_ctr
  import booth_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle holding count TIMEOUT-1 is the TIMEOUT-th wait cycle.
  assign expired_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/booth_job_sequencer.sv
// Feeds one operand pair at a time to a serial-load Booth multiplier and returns its product.
module booth_job_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   op_m,
  input  logic [WIDTH-1:0]   op_q,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_data,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_product,
  output logic               res_err
);

  localparam int unsigned PW = 2 * WIDTH;

  booth_state_e   state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             op_ready_q, op_ready_d;
  logic             mul_start_q, mul_start_d;
  logic [WIDTH-1:0] mul_data_q, mul_data_d;
  logic             res_valid_q, res_valid_d;
  logic [PW-1:0]    res_product_q, res_product_d;
  logic             res_err_q, res_err_d;
  logic             cnt_clr, cnt_en, expired_c;

  booth_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_c (expired_c)
  );

  // Next-state and next-output logic; outputs are decoded from the next state so they align with it.
  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    q_d           = q_q;
    res_product_d = res_product_q;
    res_err_d     = res_err_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready_q) begin
          m_d     = op_m;
          q_d     = op_q;
          cnt_clr = 1'b1;
          state_d = ST_LOAD_M;
        end
      end
      ST_LOAD_M: state_d = ST_LOAD_Q;
      ST_LOAD_Q: state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        // A done level left over from the previous job must drop before we look for a new one.
        cnt_en = 1'b1;
        if (expired_c) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          state_d       = ST_HOLD;
        end else if (!mul_done) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // Completion takes priority over a coincident timeout.
        cnt_en = 1'b1;
        if (mul_done) begin
          res_product_d = mul_product;
          res_err_d     = 1'b0;
          state_d       = ST_HOLD;
        end else if (expired_c) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    op_ready_d  = (state_d == ST_IDLE);
    mul_start_d = (state_d == ST_LOAD_M);
    res_valid_d = (state_d == ST_HOLD);
    mul_data_d  = '0;
    if (state_d == ST_LOAD_M) begin
      mul_data_d = m_d;
    end else if (state_d == ST_LOAD_Q) begin
      mul_data_d = q_d;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      m_q           <= '0;
      q_q           <= '0;
      op_ready_q    <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      q_q           <= q_d;
      op_ready_q    <= op_ready_d;
      mul_start_q   <= mul_start_d;
      mul_data_q    <= mul_data_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_err_q     <= res_err_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign mul_start   = mul_start_q;
  assign mul_data    = mul_data_q;
  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_err     = res_err_q;

endmodule

// File: doc/booth_job_sequencer.md
BOOTH_JOB_SEQUENCER -- requirements
Module: booth_job_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand width; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for mul_done before aborting a job.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_valid  input  1  upstream operand pair valid.
REQ-006 op_ready  output  1  sequencer can accept an operand pair.
REQ-007 op_m  input  WIDTH  multiplicand, signed two's complement.
REQ-008 op_q  input  WIDTH  multiplier, signed two's complement.
REQ-009 mul_start  output  1  start strobe to the Booth multiplier.
REQ-010 mul_data  output  WIDTH  serial operand bus to the multiplier: M, then Q.
REQ-011 mul_done  input  1  multiplier completion flag (level).
REQ-012 mul_product  input  2*WIDTH  multiplier result.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  downstream accepts result.
REQ-015 res_product  output  2*WIDTH  captured product.
REQ-016 res_err  output  1  qualifies res_valid; 1 = job aborted by timeout, res_product = 0.

Function
REQ-017 FSM states: IDLE, LOAD_M, LOAD_Q, WAIT_LOW, WAIT_DONE, HOLD.
REQ-018 IDLE: op_ready=1; op_valid&op_ready captures op_m/op_q into internal registers and moves to LOAD_M next cycle.
REQ-019 LOAD_M (exactly 1 cycle): mul_start=1, mul_data=captured M; then LOAD_Q.
REQ-020 LOAD_Q (exactly 1 cycle): mul_start=0, mul_data=captured Q; then WAIT_LOW.
REQ-021 WAIT_LOW: waits for mul_done=0 (stale done from previous job ignored); then WAIT_DONE.
REQ-022 WAIT_DONE: first cycle with mul_done=1 captures mul_product into res_product, res_err=0, goes to HOLD.
REQ-023 Timeout counter clears on entry to LOAD_M, increments every cycle in WAIT_LOW/WAIT_DONE; reaching TIMEOUT goes to HOLD with res_err=1, res_product=0.
REQ-024 mul_done and timeout in the same cycle: mul_done wins (valid product, res_err=0).
REQ-025 HOLD: res_valid=1; res_product/res_err stable until res_valid&res_ready; then IDLE.
REQ-026 op_ready=1 only in IDLE; one job in flight; no input accepted while result unconsumed.
REQ-027 mul_data=0 and mul_start=0 in all states other than LOAD_M/LOAD_Q.
REQ-028 Latency op accept -> res_valid = 3 + wait cycles (WAIT_LOW + WAIT_DONE residency), minimum 5 cycles.
REQ-029 Product passed through unmodified; no sign extension or truncation in the sequencer.
REQ-030 Registered outputs: op_ready, mul_start, mul_data, res_valid, res_product, res_err.

Reset
REQ-031 rst_n low: state=IDLE, op_ready=0 while asserted, then 1 in IDLE; mul_start=0, mul_data=0, res_valid=0, res_err=0, res_product=0, timeout counter=0, operand registers=0.
REQ-032 Reset mid-job discards the job with no res_valid; first cycle after release is IDLE.

Structure
REQ-033 Shared package booth_pkg holds the FSM state encoding typedef and WIDTH/TIMEOUT defaults.
REQ-034 Flat module; optional sub-module booth_timeout_ctr (clear/enable/expired) for the watchdog.

Verification
REQ-035 M=5, Q=30, model done 8 cycles after LOAD_Q with product=150 -> mul_data 5 then 30 in consecutive cycles, mul_start high only with 5, res_product=150, res_err=0.
REQ-036 M=-3, Q=7, product=-21 -> res_product=16'hFFEB.
REQ-037 mul_done held high from previous job at LOAD_Q -> no capture until done drops and re-rises; correct new product.
REQ-038 mul_done never asserts, TIMEOUT=16 -> res_valid with res_err=1, res_product=0, exactly 16 wait cycles after LOAD_Q.
REQ-039 res_ready held low 10 cycles -> res_valid/res_product stable, op_ready=0, new op_valid ignored; accepted the cycle after handshake returns to IDLE.
REQ-040 rst_n asserted in WAIT_DONE -> all outputs zero immediately; no result emitted; next job completes normally.
